// File: rtl/clb_cfg_if.sv
// Bundle of logic, control and configuration-chain signals for clb_cfg.
interface clb_cfg_if #(
    parameter int unsigned LUT_INPUTS = 4,
    parameter int unsigned NUM_LUTS   = 2
);
    logic [LUT_INPUTS-1:0] I;
    logic                  SET_IN;
    logic                  RST_IN;
    logic                  CFG_EN;
    logic                  CFG_DIN;
    logic                  CFG_DOUT;
    logic                  CFG_DONE;
    logic [NUM_LUTS-1:0]   O;

    modport master (
        output I, SET_IN, RST_IN, CFG_EN, CFG_DIN,
        input  CFG_DOUT, CFG_DONE, O
    );

    modport slave (
        input  I, SET_IN, RST_IN, CFG_EN, CFG_DIN,
        output CFG_DOUT, CFG_DONE, O
    );
endinterface

// File: rtl/clb_cfg.sv
// Configurable logic block: serially loaded LUT/flop cells with a load-tracking FSM.
// Define CLB_CFG_READBACK_EN to drive CFG_DOUT with the bit shifted out of the chain.
module clb_cfg #(
    parameter int unsigned LUT_INPUTS = 4,
    parameter int unsigned NUM_LUTS   = 2
) (
    input logic      K,
    input logic      RST,
    clb_cfg_if.slave bus
);
    localparam int unsigned TW  = 2 ** LUT_INPUTS;
    localparam int unsigned W   = TW + 4;
    localparam int unsigned LEN = NUM_LUTS * W;
    localparam int unsigned CW  = $clog2(LEN + 1);

    typedef enum logic [1:0] {StUncfg, StLoad, StActive} state_e;

    state_e              state_q, state_d;
    logic [LEN-1:0]      chain_q, chain_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_LUTS-1:0] q_q, q_d;
    logic                done_q, done_d;

    logic [NUM_LUTS-1:0] f, osel, fb, sen, ren;
    logic                active;

    assign active = (state_q == StActive);

    for (genvar j = 0; j < NUM_LUTS; j++) begin : g_cell
        localparam int unsigned Base = j * W;
        logic [TW-1:0]         tt;
        logic [LUT_INPUTS-1:0] idx;

        assign tt      = chain_q[Base +: TW];
        assign osel[j] = chain_q[Base + TW];
        assign fb[j]   = chain_q[Base + TW + 1];
        assign sen[j]  = chain_q[Base + TW + 2];
        assign ren[j]  = chain_q[Base + TW + 3];

        // Feedback mode lets the cell see its own flop on the lowest LUT input.
        always_comb begin
            idx = bus.I;
            if (fb[j]) idx[0] = q_q[j];
        end

        assign f[j] = tt[idx];
    end

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        if (bus.CFG_EN) begin
            chain_d = {bus.CFG_DIN, chain_q[LEN-1:1]};
            if (state_q == StLoad) begin
                if (cnt_q == CW'(LEN - 1)) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                state_d = StLoad;
                cnt_d   = CW'(1);
            end
        end
        done_d = (state_d == StActive);
        // Clear beats set beats LUT value.
        q_d = active ? (~(ren & {NUM_LUTS{bus.RST_IN}}) & ((sen & {NUM_LUTS{bus.SET_IN}}) | f))
                     : q_q;
    end

    always_ff @(posedge K) begin
        if (RST) begin
            state_q <= StUncfg;
            chain_q <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

`ifdef CLB_CFG_READBACK_EN
    logic dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (bus.CFG_EN) dout_d = chain_q[0];
    end

    always_ff @(posedge K) begin
        if (RST) dout_q <= 1'b0;
        else     dout_q <= dout_d;
    end

    assign bus.CFG_DOUT = dout_q;
`else
    assign bus.CFG_DOUT = 1'b0;
`endif

    assign bus.CFG_DONE = done_q;
    assign bus.O        = active ? ((osel & q_q) | (~osel & f)) : '0;
endmodule

// File: tb/tb_clb_cfg.sv
// Directed bench for clb_cfg with LUT_INPUTS=4, NUM_LUTS=2 (40-bit chain).
module tb_clb_cfg;
    logic K;
    logic RST;
    int   n_checks;
    int   n_fail;

    clb_cfg_if #(.LUT_INPUTS(4), .NUM_LUTS(2)) bus ();

    clb_cfg #(.LUT_INPUTS(4), .NUM_LUTS(2)) dut (
        .K   (K),
        .RST (RST),
        .bus (bus)
    );

    initial K = 1'b0;
    always #5 K = ~K;

    task automatic tick();
        @(posedge K);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        bus.CFG_EN  = 1'b1;
        bus.CFG_DIN = b;
        tick();
    endtask

    // Shifts v index 0 first; optional pause before bit pause_at.
    task automatic load(input logic [39:0] v, input int pause_at, input int pause_len);
        for (int k = 0; k < 40; k++) begin
            if (k == pause_at) begin
                bus.CFG_EN = 1'b0;
                for (int p = 0; p < pause_len; p++) begin
                    tick();
                    chk("pause_done", 32'(bus.CFG_DONE), 32'd0);
                    chk("pause_o", 32'(bus.O), 32'd0);
                end
            end
            shift_bit(v[k]);
            if (k < 39) begin
                chk("load_done", 32'(bus.CFG_DONE), 32'd0);
                chk("load_o", 32'(bus.O), 32'd0);
            end
        end
        bus.CFG_EN  = 1'b0;
        bus.CFG_DIN = 1'b0;
        chk("done_after_40", 32'(bus.CFG_DONE), 32'd1);
    endtask

    task automatic set_i(input logic [3:0] v);
        bus.I = v;
        #1;
    endtask

    logic [39:0] cfg1, cfg_sr, cfg_fb;
    logic        exp_dout;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        RST         = 1'b1;
        bus.I       = 4'h0;
        bus.SET_IN  = 1'b0;
        bus.RST_IN  = 1'b0;
        bus.CFG_EN  = 1'b0;
        bus.CFG_DIN = 1'b0;
        cfg1   = {20'h18000, 20'h00116};
        cfg_sr = {20'hD0000, 20'h00000};
        cfg_fb = {20'h00000, 20'h35555};

        tick();
        tick();
        RST = 1'b0;
        chk("rst_done", 32'(bus.CFG_DONE), 32'd0);
        chk("rst_o", 32'(bus.O), 32'd0);
        chk("rst_dout", 32'(bus.CFG_DOUT), 32'd0);

        // Basic load: cell0 one-hot detector (comb), cell1 4-input AND (registered)
        load(cfg1, -1, 0);
        set_i(4'h1);
        chk("comb_i1", 32'(bus.O), 32'd1);
        set_i(4'h3);
        chk("comb_i3", 32'(bus.O), 32'd0);
        set_i(4'hF);
        chk("reg_before_edge", 32'(bus.O), 32'd0);
        tick();
        chk("reg_after_edge", 32'(bus.O), 32'd2);
        set_i(4'h0);
        chk("reg_hold", 32'(bus.O), 32'd2);
        tick();
        chk("reg_clear", 32'(bus.O), 32'd0);

        // Paused load
        reset_pulse();
        chk("rst2_done", 32'(bus.CFG_DONE), 32'd0);
        load(cfg1, 20, 5);
        set_i(4'h8);
        chk("pause_cfg_ok", 32'(bus.O), 32'd1);

        // Set/clear priority on cell1
        reset_pulse();
        load(cfg_sr, -1, 0);
        bus.SET_IN = 1'b1;
        bus.RST_IN = 1'b1;
        tick();
        chk("set_rst_both", 32'(bus.O), 32'd0);
        bus.RST_IN = 1'b0;
        tick();
        chk("set_only", 32'(bus.O), 32'd2);
        bus.SET_IN = 1'b0;
        tick();
        chk("lut_zero", 32'(bus.O), 32'd0);
        bus.SET_IN = 1'b1;
        tick();
        chk("set_again", 32'(bus.O), 32'd2);
        bus.SET_IN = 1'b0;
        bus.RST_IN = 1'b1;
        tick();
        chk("rst_only", 32'(bus.O), 32'd0);
        bus.RST_IN = 1'b0;

        // Feedback toggle on cell0
        reset_pulse();
        set_i(4'h0);
        load(cfg_fb, -1, 0);
        chk("tog_init", 32'(bus.O), 32'd0);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("toggle", 32'(bus.O), (t % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Reset during load at bit 25
        reset_pulse();
        for (int k = 0; k < 24; k++) shift_bit(cfg1[k]);
        bus.CFG_EN = 1'b1;
        RST        = 1'b1;
        tick();
        RST        = 1'b0;
        bus.CFG_EN = 1'b0;
        chk("midrst_done", 32'(bus.CFG_DONE), 32'd0);
        chk("midrst_o", 32'(bus.O), 32'd0);
        load(cfg1, -1, 0);
        set_i(4'h2);
        chk("reload_ok", 32'(bus.O), 32'd1);

        // Readback: shifting zeros replays cfg1 index 0 first
        for (int k = 0; k < 40; k++) begin
            shift_bit(1'b0);
`ifdef CLB_CFG_READBACK_EN
            exp_dout = cfg1[k];
`else
            exp_dout = 1'b0;
`endif
            chk("readback", 32'(bus.CFG_DOUT), 32'(exp_dout));
        end
        bus.CFG_EN = 1'b0;
        chk("zero_cfg_done", 32'(bus.CFG_DONE), 32'd1);
        chk("zero_cfg_o", 32'(bus.O), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
